// File: rtl/voice_frame_sequencer.sv
// Time-multiplexes one waveform datapath across NUM_VOICES voices: one request per active voice
// per codec sample slot, then the averaged mix is written to the audio FIFO.
module voice_frame_sequencer #(
  parameter int NUM_VOICES  = 4,
  parameter int PHASE_W     = 24,
  parameter int SAMPLE_W    = 24,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                            CLOCK_50,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NUM_VOICES-1:0]           voice_on,
  input  logic [NUM_VOICES*PHASE_W-1:0]   voice_inc,
  output logic                            osc_req,
  output logic [PHASE_W-1:0]              osc_phase,
  output logic [$clog2(NUM_VOICES)-1:0]   osc_voice,
  input  logic                            osc_ack,
  input  logic [SAMPLE_W-1:0]             osc_sample,
  input  logic                            audio_out_allowed,
  output logic                            write_audio_out,
  output logic [SAMPLE_W-1:0]             left_channel_out,
  output logic [SAMPLE_W-1:0]             right_channel_out,
  output logic                            busy,
  output logic                            timeout_err,
  output logic [2:0]                      state_dbg
);

  localparam int VW    = $clog2(NUM_VOICES);
  localparam int ACC_W = SAMPLE_W + VW;
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [VW-1:0]    LAST_V  = VW'(NUM_VOICES - 1);
  localparam logic [CNT_W-1:0] LAST_WT = CNT_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_REQ   = 3'd2,
    S_NEXT  = 3'd3,
    S_MIX   = 3'd4,
    S_WRITE = 3'd5
  } state_t;

  state_t                    state, state_n;
  logic [NUM_VOICES-1:0]     mask;
  logic [VW-1:0]             v;
  logic signed [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]          wait_cnt;
  logic [PHASE_W-1:0]        phase_acc [NUM_VOICES];

  logic start_frame, adv_v, take_ack, take_to, req_wait, do_mix;
  logic [PHASE_W-1:0]        inc_v;
  logic signed [ACC_W-1:0]   sample_ext;

  assign inc_v      = voice_inc[v*PHASE_W +: PHASE_W];
  assign sample_ext = {{VW{osc_sample[SAMPLE_W-1]}}, osc_sample};

  always_comb begin
    state_n     = state;
    start_frame = 1'b0;
    adv_v       = 1'b0;
    take_ack    = 1'b0;
    take_to     = 1'b0;
    req_wait    = 1'b0;
    do_mix      = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && audio_out_allowed) begin
          start_frame = 1'b1;
          state_n     = S_SCAN;
        end
      end
      S_SCAN: begin
        if (mask[v])          state_n = S_REQ;
        else if (v == LAST_V) state_n = S_MIX;
        else                  adv_v   = 1'b1;
      end
      // An ack on the final wait cycle still wins over the timeout.
      S_REQ: begin
        if (osc_ack) begin
          take_ack = 1'b1;
          state_n  = S_NEXT;
        end else if (wait_cnt == LAST_WT) begin
          take_to  = 1'b1;
          state_n  = S_NEXT;
        end else begin
          req_wait = 1'b1;
        end
      end
      S_NEXT: begin
        if (v == LAST_V) begin
          state_n = S_MIX;
        end else begin
          adv_v   = 1'b1;
          state_n = S_SCAN;
        end
      end
      S_MIX: begin
        do_mix  = 1'b1;
        state_n = S_WRITE;
      end
      S_WRITE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Handshake: osc_req stays high with osc_voice/osc_phase stable until the cycle osc_ack is
  // sampled high (or the wait expires); osc_ack is ignored in every other state.
  assign osc_req         = (state == S_REQ);
  assign osc_voice       = (state == S_REQ) ? v : '0;
  assign osc_phase       = (state == S_REQ) ? phase_acc[v] : '0;
  assign write_audio_out = (state == S_WRITE);
  assign busy            = (state != S_IDLE);
  assign state_dbg       = state;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state             <= S_IDLE;
      mask              <= '0;
      v                 <= '0;
      acc               <= '0;
      wait_cnt          <= '0;
      timeout_err       <= 1'b0;
      left_channel_out  <= '0;
      right_channel_out <= '0;
      for (int i = 0; i < NUM_VOICES; i++) phase_acc[i] <= '0;
    end else begin
      state <= state_n;
      if (start_frame) begin
        mask <= voice_on;
        v    <= '0;
        acc  <= '0;
      end
      if (adv_v) v <= v + 1'b1;
      wait_cnt <= req_wait ? wait_cnt + 1'b1 : '0;
      if (take_ack) acc <= acc + sample_ext;
      // A timed-out voice loses its sample but keeps its pitch.
      if (take_ack || take_to) phase_acc[v] <= phase_acc[v] + inc_v;
      if (take_to) timeout_err <= 1'b1;
      if (do_mix) begin
        left_channel_out  <= acc[ACC_W-1:VW];
        right_channel_out <= acc[ACC_W-1:VW];
      end
    end
  end

endmodule

// File: tb/tb_voice_frame_sequencer.sv
// Directed bench for voice_frame_sequencer: a responder models the waveform datapath, a scoreboard
// holds expected requests and mixes computed from a phase model.
module tb_voice_frame_sequencer;
  localparam int NV  = 4;
  localparam int PW  = 24;
  localparam int SW  = 24;
  localparam int TO  = 64;
  localparam int VW  = 2;
  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, enable, audio_out_allowed, osc_ack;
  logic [NV-1:0]       voice_on;
  logic [NV*PW-1:0]    voice_inc;
  logic                osc_req;
  logic [PW-1:0]       osc_phase;
  logic [VW-1:0]       osc_voice;
  logic [SW-1:0]       osc_sample;
  logic                write_audio_out;
  logic [SW-1:0]       left_channel_out, right_channel_out;
  logic                busy, timeout_err;
  logic [2:0]          state_dbg;

  voice_frame_sequencer #(
    .NUM_VOICES(NV), .PHASE_W(PW), .SAMPLE_W(SW), .ACK_TIMEOUT(TO)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .enable(enable), .voice_on(voice_on), .voice_inc(voice_inc),
    .osc_req(osc_req), .osc_phase(osc_phase), .osc_voice(osc_voice), .osc_ack(osc_ack),
    .osc_sample(osc_sample), .audio_out_allowed(audio_out_allowed),
    .write_audio_out(write_audio_out), .left_channel_out(left_channel_out),
    .right_channel_out(right_channel_out), .busy(busy), .timeout_err(timeout_err),
    .state_dbg(state_dbg)
  );

  int n_cmp = 0;
  int n_err = 0;
  int writes_seen = 0;
  int resp_age = 0;
  logic [VW+PW-1:0] exp_req_q[$];
  logic [SW-1:0]    exp_q[$];
  logic [PW-1:0]    model_phase [NV];
  logic [PW-1:0]    inc_tab [NV];
  logic [SW-1:0]    samp_tab [NV];
  logic [NV-1:0]    noack = '0;
  logic             req_prev = 1'b0;
  logic [VW+PW-1:0] req_hold;
  logic [SW-1:0]    mon_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_inc();
    for (int v = 0; v < NV; v++) voice_inc[v*PW +: PW] = inc_tab[v];
  endtask

  task automatic clear_model();
    for (int v = 0; v < NV; v++) model_phase[v] = '0;
    exp_req_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_model();
  endtask

  // Waveform datapath model: acks LAT cycles into a request unless the voice is marked dead.
  initial begin
    osc_ack    = 1'b0;
    osc_sample = '0;
    forever begin
      @(negedge clk);
      if (osc_req) begin
        resp_age++;
        if (resp_age == LAT && !noack[osc_voice]) begin
          osc_ack    = 1'b1;
          osc_sample = samp_tab[osc_voice];
        end else begin
          osc_ack    = 1'b0;
          osc_sample = 24'h5a5a5a;
        end
      end else begin
        resp_age = 0;
        osc_ack  = 1'b0;
      end
    end
  end

  // Output monitor: pops the scoreboard on each new request and on each FIFO write.
  initial begin
    forever begin
      @(negedge clk);
      if (osc_req && !req_prev) begin
        check("req_expected", exp_req_q.size() != 0, 1'b1);
        if (exp_req_q.size() != 0) begin
          req_hold = exp_req_q.pop_front();
          check("req_voice_phase", {osc_voice, osc_phase}, req_hold);
        end else begin
          req_hold = {osc_voice, osc_phase};
        end
      end else if (osc_req && req_prev) begin
        check("req_stable", {osc_voice, osc_phase}, req_hold);
      end
      req_prev = osc_req;
      if (write_audio_out) begin
        writes_seen++;
        check("write_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check("left_mix", left_channel_out, mon_exp);
          check("right_mix", right_channel_out, mon_exp);
        end
      end
    end
  end

  // One frame: predict requests, mix and busy length, pulse enable, then let the frame drain.
  task automatic run_frame(input logic [NV-1:0] on, input string tag);
    int sum, mix, exp_busy, cnt, cyc, w0;
    sum = 0;
    exp_busy = 2;
    for (int v = 0; v < NV; v++) begin
      exp_busy += 1;
      if (on[v]) begin
        exp_req_q.push_back({VW'(v), model_phase[v]});
        exp_busy += (noack[v] ? TO : LAT) + 1;
        if (!noack[v]) sum += int'($signed(samp_tab[v]));
      end
    end
    mix = sum >>> 2;
    exp_q.push_back(mix[SW-1:0]);
    w0  = writes_seen;
    cnt = 0;
    cyc = 0;
    voice_on = on;
    enable   = 1'b1;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (osc_req || write_audio_out) enable = 1'b0;
      if (busy) cnt++;
      else if (cnt > 0) break;
    end
    enable = 1'b0;
    check({tag, "_busy_cycles"}, cnt, exp_busy);
    check({tag, "_writes"}, writes_seen - w0, 1);
    check({tag, "_req_drained"}, exp_req_q.size(), 0);
    for (int v = 0; v < NV; v++)
      if (on[v]) model_phase[v] = model_phase[v] + inc_tab[v];
  endtask

  initial begin
    int w0, cyc;
    logic found;
    reset = 1'b1;
    enable = 1'b0;
    audio_out_allowed = 1'b1;
    voice_on = '0;
    inc_tab[0] = 24'h001000; inc_tab[1] = 24'h023456;
    inc_tab[2] = 24'h100000; inc_tab[3] = 24'h000007;
    for (int v = 0; v < NV; v++) samp_tab[v] = SW'(1000);
    apply_inc();
    repeat (2) @(negedge clk);
    do_reset();

    check("rst_osc_req", osc_req, 1'b0);
    check("rst_osc_phase", osc_phase, 0);
    check("rst_osc_voice", osc_voice, 0);
    check("rst_write", write_audio_out, 1'b0);
    check("rst_left", left_channel_out, 0);
    check("rst_right", right_channel_out, 0);
    check("rst_busy", busy, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_state", state_dbg, 3'd0);

    // All voices on, every sample +1000; phases accumulate k*inc across frames.
    for (int k = 0; k < 4; k++) run_frame(4'b1111, "t1_all_on");

    // Sparse mask: only voices 0 and 2 requested, idle voices keep phase 0.
    do_reset();
    samp_tab[0] = SW'(4000); samp_tab[1] = SW'(0);
    samp_tab[2] = SW'(-2000); samp_tab[3] = SW'(0);
    run_frame(4'b0101, "t2_sparse");
    run_frame(4'b0101, "t2_sparse");
    run_frame(4'b1111, "t2_all_after_sparse");
    samp_tab[0] = SW'(-3);
    run_frame(4'b0001, "t2_neg_floor");
    run_frame(4'b0000, "t2_empty_mask");
    check("t2_hold_between_frames", left_channel_out, 0);

    // Phase wraps modulo 2^PHASE_W.
    do_reset();
    inc_tab[0] = 24'hffffff;
    apply_inc();
    samp_tab[0] = SW'(1000);
    for (int k = 0; k < 3; k++) run_frame(4'b0001, "t3_wrap");
    check("t3_no_timeout", timeout_err, 1'b0);

    // Voice 1 never answers: frame waits out the timeout and mixes without it.
    do_reset();
    inc_tab[0] = 24'h001000;
    apply_inc();
    samp_tab[0] = SW'(800); samp_tab[1] = SW'(9999);
    samp_tab[2] = SW'(-400); samp_tab[3] = SW'(1200);
    noack = 4'b0010;
    run_frame(4'b1111, "t4_timeout");
    check("t4_timeout_err_set", timeout_err, 1'b1);
    noack = 4'b0000;
    run_frame(4'b1111, "t4_recover");
    check("t4_timeout_err_sticky", timeout_err, 1'b1);

    // Blocked starts: no FIFO space, or enable low.
    w0 = writes_seen;
    audio_out_allowed = 1'b0;
    enable = 1'b1;
    repeat (20) @(negedge clk);
    check("t5_no_space_busy", busy, 1'b0);
    check("t5_no_space_req", osc_req, 1'b0);
    audio_out_allowed = 1'b1;
    enable = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_disabled_busy", busy, 1'b0);
    check("t5_no_writes", writes_seen - w0, 0);

    // Reset while voice 2 is being served aborts the frame and clears all phases.
    for (int v = 0; v < NV; v++) samp_tab[v] = SW'(1000);
    for (int v = 0; v < NV; v++) exp_req_q.push_back({VW'(v), model_phase[v]});
    voice_on = 4'b1111;
    enable = 1'b1;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (osc_req) enable = 1'b0;
      if (osc_req && osc_voice == 2'd2) found = 1'b1;
    end
    check("t6_reached_v2", found, 1'b1);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    check("t6_state_idle", state_dbg, 3'd0);
    check("t6_req_low", osc_req, 1'b0);
    check("t6_busy_low", busy, 1'b0);
    reset = 1'b0;
    clear_model();
    w0 = writes_seen;
    repeat (10) @(negedge clk);
    check("t6_no_aborted_write", writes_seen - w0, 0);
    check("t6_timeout_err_cleared", timeout_err, 1'b0);
    run_frame(4'b1111, "t6_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
